pulse_sequencer: RTL

Sequences a burst of square pulses on a measurement output pin, counting in ticks from an upstream clock-divider strobe. It latches the pulse count and half-period on a start request, runs the burst, and reports completion with a one-cycle done pulse. It sits between the divider's tick output and the scope/logic-analyser pin, replacing the free-running fixed-count counter so software-visible or switch-driven bursts can be scheduled repeatedly.

---
 rtl/pulse_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - tick-timed square-pulse burst generator; optional abort via PULSE_SEQUENCER_ABORT_EN
module pulse_sequencer #(
    parameter int CNTW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_tick,
    input  logic            i_start,
    input  logic [CNTW-1:0] i_burst_len,
    input  logic [CNTW-1:0] i_half_period,
    input  logic            i_abort,
    output logic            o_out,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_aborted,
    output logic [CNTW-1:0] o_pulse_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [CNTW-1:0] r_phase;
    logic [CNTW-1:0] r_remaining;
    logic [CNTW-1:0] r_hp;
    logic [CNTW-1:0] r_pulse_count;
    logic            r_out;
    logic            r_busy;
    logic            r_done;
    logic            r_aborted;

    logic            w_abort;
    logic            w_phase_last;
    logic [CNTW-1:0] w_hp_in;

`ifdef PULSE_SEQUENCER_ABORT_EN
    assign w_abort = i_abort;
`else
    // Abort is accepted on the port but has no effect in this build.
    logic w_unused_abort;
    assign w_unused_abort = i_abort;
    assign w_abort        = 1'b0;
`endif

    // A zero half-period would never terminate a phase, so it is promoted to one tick.
    assign w_hp_in      = (i_half_period == '0) ? ONE : i_half_period;
    assign w_phase_last = (r_phase == (r_hp - ONE));

    // Burst state machine; all outputs are registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_phase       <= '0;
            r_remaining   <= '0;
            r_hp          <= '0;
            r_pulse_count <= '0;
            r_out         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pulse_count <= '0;
                        r_aborted     <= 1'b0;
                        if (i_burst_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_remaining <= i_burst_len;
                            r_hp        <= w_hp_in;
                            r_phase     <= '0;
                            r_state     <= S_HIGH;
                            r_out       <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (w_abort) begin
                        r_state   <= S_DONE;
                        r_out     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (i_tick) begin
                        if (w_phase_last) begin
                            r_phase <= '0;
                            r_state <= S_LOW;
                            r_out   <= 1'b0;
                        end else begin
                            r_phase <= r_phase + ONE;
                        end
                    end
                end
                S_LOW: begin
                    if (w_abort) begin
                        r_state   <= S_DONE;
                        r_out     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (i_tick) begin
                        if (w_phase_last) begin
                            r_phase       <= '0;
                            r_pulse_count <= r_pulse_count + ONE;
                            r_remaining   <= r_remaining - ONE;
                            if (r_remaining == ONE) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_HIGH;
                                r_out   <= 1'b1;
                            end
                        end else begin
                            r_phase <= r_phase + ONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_out         = r_out;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_aborted     = r_aborted;
    assign o_pulse_count = r_pulse_count;

endmodule
